// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable integer clock divider with glitch-free bypass.
//
// Purpose:
//   Divides clk_i by a runtime-programmable integer N. The divisor is changed
//   through a valid/ready request port. New divisors, and entry to or exit
//   from bypass (N <= 1), take effect without runt pulses on clk_o.
//
// Ports:
//   clk_i        root clock
//   rst_ni       asynchronous active-low reset
//   en_i         run enable for the divided clock
//   div_i        requested divisor (0 and 1 select bypass)
//   div_valid_i  divisor request valid
//   div_ready_o  divisor request ready
//   clk_o        divided, bypassed or stopped clock
//   active_o     high while clk_o toggles
//
// Handshake: a request transfers on a posedge where div_valid_i and
// div_ready_o are both high. div_ready_o then stays low until the request
// has been applied, and div_valid_i is ignored while div_ready_o is low.
//
// Optional build macro: CLK_DIV_ODD_DUTY50_EN. When defined, odd divisors
// (N >= 3) give a 50% duty cycle through a half-cycle-delayed copy of the
// divided flop ORed onto it.
//
// Clock-path cells (tc_clk_*) are provided at the top of this file.

module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);
  assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module tc_clk_and2 (
  input  logic clk0_i,
  input  logic clk1_i,
  output logic clk_o
);
  assign clk_o = clk0_i & clk1_i;
endmodule

`ifdef CLK_DIV_ODD_DUTY50_EN
module tc_clk_or2 (
  input  logic clk0_i,
  input  logic clk1_i,
  output logic clk_o
);
  assign clk_o = clk0_i | clk1_i;
endmodule
`endif

module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             clk_o,
  output logic             active_o
);

  localparam logic [DIV_W-1:0] DEF_N   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic             DEF_BYP = (DEFAULT_DIV <= 1);

  // ST_IDLE: divider stopped (cnt 0, div_q 0); ST_RUN: divider counting;
  // ST_BYP_OFF / ST_BYP_ON: bypass with the output gated off / on.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BYP_OFF = 2'd2,
    ST_BYP_ON  = 2'd3
  } state_e;

  localparam state_e RST_STATE = DEF_BYP ? ST_BYP_OFF : ST_IDLE;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             byp_sel_q, byp_sel_d;
  logic             byp_en_q, byp_en_d;

  logic             wrap;
  logic             apply;
  logic [DIV_W-1:0] half;
  logic             in_byp;

  assign wrap        = (cnt_q == (n_q - ONE));
  assign half        = n_q >> 1;
  assign in_byp      = (state_q == ST_BYP_OFF) || (state_q == ST_BYP_ON);
  assign div_ready_o = !pend_q;
  assign active_o    = (state_q == ST_RUN) || (state_q == ST_BYP_ON);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    apply      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (wrap) begin
          // Period boundary: the only point where a running divider may
          // change divisor or stop, so div_q is always low when it does.
          cnt_d = '0;
          apply = pend_q;
          if (en_i) begin
            div_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            div_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          div_d = (cnt_d < half);
        end
      end
      ST_IDLE: begin
        apply = pend_q;
        if (en_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          div_d   = 1'b1;
        end
      end
      default: begin
        apply   = pend_q;
        state_d = en_i ? ST_BYP_ON : ST_BYP_OFF;
        cnt_d   = '0;
        div_d   = 1'b0;
      end
    endcase

    if (apply) begin
      n_d    = pend_val_q;
      pend_d = 1'b0;
      cnt_d  = '0;
      if (pend_val_q <= ONE) begin
        state_d = en_i ? ST_BYP_ON : ST_BYP_OFF;
        div_d   = 1'b0;
      end else if (in_byp) begin
        // Leave bypass through IDLE so div_q is still low when the
        // negedge select flop switches back to the divider.
        state_d = ST_IDLE;
        div_d   = 1'b0;
      end
    end

    if (div_valid_i && div_ready_o) begin
      pend_d     = 1'b1;
      pend_val_d = div_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RST_STATE;
      n_q        <= DEF_N;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  // Bypass select and gate enable change on the falling edge, while clk_i
  // is low and div_q is low, so the output mux never switches mid-pulse.
  assign byp_sel_d = in_byp;
  assign byp_en_d  = (state_q == ST_BYP_ON);

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_sel_q <= DEF_BYP;
      byp_en_q  <= 1'b0;
    end else begin
      byp_sel_q <= byp_sel_d;
      byp_en_q  <= byp_en_d;
    end
  end

  logic div_clk;
  logic byp_clk;

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic dly_q, dly_d;

  // Only odd divisors get the half-cycle extension; in bypass div_q is 0.
  assign dly_d = div_q & n_q[0];

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
    end
  end

  tc_clk_or2 u_duty_or (
    .clk0_i (div_q),
    .clk1_i (dly_q),
    .clk_o  (div_clk)
  );
`else
  assign div_clk = div_q;
`endif

  tc_clk_and2 u_byp_gate (
    .clk0_i (clk_i),
    .clk1_i (byp_en_q),
    .clk_o  (byp_clk)
  );

  tc_clk_mux2 u_out_mux (
    .clk0_i    (div_clk),
    .clk1_i    (byp_clk),
    .clk_sel_i (byp_sel_q),
    .clk_o     (clk_o)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: self-checking bench for clk_div_ctrl (DIV_W=8, DEFAULT_DIV=2).
// Periods and high times of clk_o are measured in half clk_i cycles.

module tb_clk_div_ctrl;

  localparam int DIV_W = 8;

  logic             clk_i       = 1'b0;
  logic             rst_ni      = 1'b0;
  logic             en_i        = 1'b0;
  logic [DIV_W-1:0] div_i       = '0;
  logic             div_valid_i = 1'b0;
  logic             div_ready_o;
  logic             clk_o;
  logic             active_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int div;
    int per_h;
    int hi_h;
  } vec_t;

  vec_t tbl[7];

  // Scoreboard: divisors accepted but not yet applied.
  logic [DIV_W-1:0] exp_q[$];

  // Pulse-width monitor.
  bit      pw_en   = 1'b0;
  longint  pw_last = 0;
  longint  pw_min  = 1000;

  clk_div_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .clk_o       (clk_o),
    .active_o    (active_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  always @(clk_o) begin
    if (pw_en) begin
      if (($time - pw_last) < pw_min) pw_min = $time - pw_last;
      pw_last = $time;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic int exp_hi(input int n);
`ifdef CLK_DIV_ODD_DUTY50_EN
    if (n % 2 == 1) return n;
`endif
    return 2 * (n / 2);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic pos();
    @(posedge clk_i);
    #1;
  endtask

  task automatic half();
    @(clk_i);
    #1;
  endtask

  // Measure one full clk_o period starting at the next rising edge.
  task automatic measure(output int per_h, output int hi_h);
    logic p;
    int   g;
    per_h = 0;
    hi_h  = 0;
    g     = 0;
    do begin
      p = clk_o;
      half();
      g++;
    end while (!(p === 1'b0 && clk_o === 1'b1) && g < 1200);
    if (g >= 1200) begin
      per_h = -1;
      hi_h  = -1;
    end else begin
      g = 0;
      do begin
        hi_h += (clk_o === 1'b1) ? 1 : 0;
        per_h++;
        p = clk_o;
        half();
        g++;
      end while (!(p === 1'b0 && clk_o === 1'b1) && g < 1200);
      if (g >= 1200) per_h = -1;
    end
  endtask

  task automatic wait_rise(input string name);
    logic p;
    int   g;
    g = 0;
    do begin
      p = clk_o;
      pos();
      g++;
    end while (!(p === 1'b0 && clk_o === 1'b1) && g < 600);
    if (g >= 600) check(name, 0, 1);
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (div_ready_o !== 1'b1 && g < 600) begin
      pos();
      g++;
    end
    check("wait_ready", div_ready_o, 1);
  endtask

  // Driver: one request; returns the number of cycles ready stayed low.
  task automatic program_div(input int n, output int low_cycles);
    @(negedge clk_i);
    div_i       = n[DIV_W-1:0];
    div_valid_i = 1'b1;
    pos();
    div_valid_i = 1'b0;
    check("req_ready_drop", div_ready_o, 0);
    low_cycles = 0;
    while (div_ready_o !== 1'b1 && low_cycles < 600) begin
      pos();
      low_cycles++;
    end
    check("req_ready_rise", div_ready_o, 1);
  endtask

  // ---------------- test ----------------
  int ph, hh, lc, cur_n, lows;
  logic s, prev_s, acc, have;
  logic [DIV_W-1:0] acc_val;
  int per, hi, cur;

  initial begin
    tbl[0] = '{5, 10, exp_hi(5)};
    tbl[1] = '{3,  6, exp_hi(3)};
    tbl[2] = '{4,  8, exp_hi(4)};
    tbl[3] = '{7, 14, exp_hi(7)};
    tbl[4] = '{8, 16, exp_hi(8)};
    tbl[5] = '{2,  4, exp_hi(2)};
    tbl[6] = '{6, 12, exp_hi(6)};

    // Reset state.
    en_i = 1'b1;
    #12;
    check("rst_clk_o", clk_o, 0);
    check("rst_active", active_o, 0);
    check("rst_ready", div_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pos();
    check("first_active", active_o, 1);
    check("first_clk_hi", clk_o, 1);
    check("first_ready", div_ready_o, 1);
    pos();
    check("first_clk_lo", clk_o, 0);
    measure(ph, hh);
    check("def_period", ph, 4);
    check("def_high", hh, 2);
    cur_n = 2;

    // Table of divisors.
    for (int i = 0; i < 7; i++) begin
      program_div(tbl[i].div, lc);
      check("tbl_ready_low_len", int'(lc >= 1 && lc <= cur_n), 1);
      for (int k = 0; k < 2; k++) begin
        measure(ph, hh);
        check("tbl_period", ph, tbl[i].per_h);
        check("tbl_high", hh, tbl[i].hi_h);
      end
      cur_n = tbl[i].div;
    end

    // Enable drop at cnt=1 with N=6, then re-enable.
    wait_rise("en_align");
    pos();
    en_i = 1'b0;
    pos();
    check("en_off_hi", clk_o, 1);
    check("en_off_act_hi", active_o, 1);
    for (int k = 0; k < 3; k++) begin
      pos();
      check("en_off_lo", clk_o, 0);
      check("en_off_act", active_o, 1);
    end
    pos();
    check("en_off_stop_clk", clk_o, 0);
    check("en_off_stop_act", active_o, 0);
    for (int k = 0; k < 4; k++) begin
      pos();
      check("en_idle_clk", clk_o, 0);
      check("en_idle_act", active_o, 0);
    end
    en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pos();
      check("en_on_hi", clk_o, 1);
      check("en_on_act", active_o, 1);
    end
    pos();
    check("en_on_lo", clk_o, 0);

    // Bypass entry, gating, and exit to N=4.
    pw_last = $time;
    pw_min  = 1000;
    pw_en   = 1'b1;
    program_div(1, lc);
    check("byp_ready_low_len", int'(lc >= 1 && lc <= 6), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #2;
      check("byp_follow_hi", clk_o, 1);
      check("byp_active", active_o, 1);
      @(negedge clk_i); #2;
      check("byp_follow_lo", clk_o, 0);
    end
    en_i = 1'b0;
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #2;
      check("byp_gated_hi", clk_o, 0);
      check("byp_gated_act", active_o, 0);
      @(negedge clk_i); #2;
      check("byp_gated_lo", clk_o, 0);
    end
    en_i = 1'b1;
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #2;
      check("byp_reen_hi", clk_o, 1);
      @(negedge clk_i); #2;
      check("byp_reen_lo", clk_o, 0);
    end
    program_div(4, lc);
    check("byp_exit_low_len", lc, 1);
    for (int k = 0; k < 2; k++) begin
      measure(ph, hh);
      check("byp_exit_period", ph, 8);
      check("byp_exit_high", hh, 4);
    end
    pw_en = 1'b0;
    check("byp_min_pulse_ok", int'(pw_min >= 5), 1);

    // Back-to-back requests 3 then 7 from N=4.
    wait_rise("b2b_align");
    div_i       = 8'd3;
    div_valid_i = 1'b1;
    fork
      begin
        pos();
        check("b2b_ready_low", div_ready_o, 0);
        div_i = 8'd7;
        lows  = 1;
        while (div_ready_o !== 1'b1 && lows < 50) begin
          pos();
          if (div_ready_o !== 1'b1) lows++;
        end
        check("b2b_low_len", lows, 3);
        pos();
        div_valid_i = 1'b0;
        check("b2b_ready_low2", div_ready_o, 0);
      end
      begin
        int p1, h1, p2, h2;
        measure(p1, h1);
        check("b2b_period3", p1, 6);
        check("b2b_high3", h1, exp_hi(3));
        measure(p2, h2);
        check("b2b_period7", p2, 14);
        check("b2b_high7", h2, exp_hi(7));
      end
    join
    wait_ready();

    // Randomized requests against the period-level reference model.
    exp_q.delete();
    cur  = 7;
    have = 1'b0;
    per  = 0;
    hi   = 0;
    @(negedge clk_i);
    #1;
    prev_s = clk_o;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i);
      acc     = div_valid_i && (exp_q.size() == 0);
      acc_val = div_i;
      #1;
      s = clk_o;
      if (prev_s === 1'b0 && s === 1'b1) begin
        if (have) begin
          check("rnd_period", per, 2 * cur);
          check("rnd_high", hi, exp_hi(cur));
        end
        if (exp_q.size() > 0) cur = int'(exp_q.pop_front());
        have = 1'b1;
        per  = 0;
        hi   = 0;
      end
      if (acc) exp_q.push_back(acc_val);
      check("rnd_ready", div_ready_o, int'(exp_q.size() == 0));
      per++;
      hi += (s === 1'b1) ? 1 : 0;
      prev_s = s;
      div_valid_i = ($urandom_range(0, 3) == 0);
      div_i       = DIV_W'($urandom_range(2, 12));
      @(negedge clk_i);
      #1;
      s = clk_o;
      per++;
      hi += (s === 1'b1) ? 1 : 0;
      prev_s = s;
    end
    div_valid_i = 1'b0;
    wait_ready();

    // Asynchronous reset while a request for 200 is pending.
    @(negedge clk_i);
    div_i       = 8'd200;
    div_valid_i = 1'b1;
    pos();
    div_valid_i = 1'b0;
    check("rst_pend_ready", div_ready_o, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_clk_o", clk_o, 0);
    check("arst_active", active_o, 0);
    check("arst_ready", div_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      measure(ph, hh);
      check("arst_def_period", ph, 4);
      check("arst_def_high", hh, 2);
    end
    check("arst_ready_after", div_ready_o, 1);

    // Largest divisor.
    program_div(255, lc);
    check("max_ready_low_len", int'(lc >= 1 && lc <= 2), 1);
    for (int k = 0; k < 2; k++) begin
      measure(ph, hh);
      check("max_period", ph, 510);
      check("max_high", hh, exp_hi(255));
    end
    check("max_active", active_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
